gpu_mem_arbiter: RTL and testbench
==================================

Name: gpu_mem_arbiter

Overview:
- Shares one byte-wide Avalon-MM master port between NUM_MASTERS gpu tile controllers, so several tiles can fetch voxels and palette entries and write pixels through a single fabric port.
- Arbitration is round-robin. One transaction is in flight at a time, and a read is held until its readdatavalid returns.
- Sits between the tile controllers' m1 interfaces and the top-level memory master.

Parameters:
- NUM_MASTERS, 4, number of requesting tile controllers (≥2).
- ADDR_BITS, 32, Avalon address width.
- DATA_BITS, 8, Avalon data width.
- IDX_BITS, $clog2(NUM_MASTERS), width of a master index.

Ports:
- clock  in  1  single clock for the block.
- reset  in  1  synchronous, active-high reset.
- s_address  in  NUM_MASTERS*ADDR_BITS  per-master address; master i occupies slice [i*ADDR_BITS +: ADDR_BITS].
- s_writedata  in  NUM_MASTERS*DATA_BITS  per-master write data.
- s_read  in  NUM_MASTERS  per-master read request.
- s_write  in  NUM_MASTERS  per-master write request.
- s_waitrequest  out  NUM_MASTERS  per-master stall.
- s_readdata  out  DATA_BITS  m_readdata broadcast to all masters.
- s_readdatavalid  out  NUM_MASTERS  per-master read-data strobe.
- m_address  out  ADDR_BITS  downstream address.
- m_writedata  out  DATA_BITS  downstream write data.
- m_read  out  1  downstream read.
- m_write  out  1  downstream write.
- m_waitrequest  in  1  downstream stall.
- m_readdata  in  DATA_BITS  downstream read data.
- m_readdatavalid  in  1  downstream read-data strobe.
- grant_idx  out  IDX_BITS  registered index of the current or most recent grantee.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- States: IDLE, ISSUE, WAIT_DATA. Encoding is 2 bits.
- Reset (synchronous, takes effect at the next edge):
  - state=IDLE, grant_idx=0, last_grant=NUM_MASTERS-1, so master 0 wins first.
  - m_read=0, m_write=0, m_address=0, m_writedata=0.
  - All s_waitrequest=1, all s_readdatavalid=0, busy=0.
- Reset mid-transaction abandons the transaction. A late m_readdatavalid that arrives in IDLE is dropped.
- IDLE:
  - req[i] = s_read[i] | s_write[i].
  - If any req is set, the grantee is the first requester at or after last_grant+1, modulo NUM_MASTERS.
  - On that edge, latch grant_idx and move to ISSUE.
  - If no req is set, stay in IDLE.
- ISSUE:
  - Combinationally forward the grantee's s_address, s_writedata, s_read and s_write to m_*.
  - s_waitrequest[g] = m_waitrequest.
  - If the grantee asserts both s_read and s_write, write wins: m_read=0, and the read stays pending for a later grant.
  - On !m_waitrequest with a write: set last_grant=g, go to IDLE.
  - On !m_waitrequest with a read:
    - if m_readdatavalid is also high that cycle, deliver the data and go to IDLE;
    - otherwise go to WAIT_DATA.
  - If the grantee drops both s_read and s_write: m_* are deasserted, last_grant=g, go to IDLE.
- WAIT_DATA:
  - m_read=0, m_write=0, and the grantee's s_waitrequest=1.
  - s_readdatavalid[g] = m_readdatavalid.
  - On the strobe: last_grant=g, go to IDLE.
  - There is no timeout; the block waits indefinitely for the strobe.
- Non-grantees see s_waitrequest=1 and s_readdatavalid=0 at all times.
- Latency:
  - A request first seen in IDLE at cycle t appears on m_* at t+1.
  - A zero-wait write occupies 2 cycles (IDLE, ISSUE).
  - A read occupies 2 cycles plus the downstream read latency.
- The read strobe reaches the requester combinationally, in the same cycle as m_readdatavalid.

Decomposition:
- Shared package gpu_pkg holds the arb_state_t enum.
- Sub-module gpu_rr_picker: purely combinational. Inputs are req[NUM_MASTERS-1:0] and last_grant. Outputs are pick_idx and pick_valid. It is instantiated once inside the arbiter.

Test Plan:
- Master 2 reads 0x1000; m_waitrequest is held for 2 cycles; m_readdatavalid arrives 3 cycles later with data 0xA5. Required: m_address=0x1000; s_readdatavalid[2] pulses once with s_readdata=0xA5; s_waitrequest stays 1 for masters 0, 1 and 3 throughout.
- All 4 masters hold continuous writes, with m_waitrequest=0. Required: grants go 0,1,2,3,0; exactly one m_write per 2 cycles; grant_idx follows that sequence.
- Masters 1 and 3 request, with last_grant=1. Required: 3 is granted first, then 1.
- Master 0 reads; m_waitrequest=0 and m_readdatavalid=1 in the same cycle. Required: the data is delivered, the block returns straight to IDLE without visiting WAIT_DATA, and busy=0 on the next cycle.
- reset is asserted in WAIT_DATA and m_readdatavalid arrives afterwards. Required: outputs take reset values the cycle after reset; no s_readdatavalid is produced; the next grant goes to master 0.
- Grantee 1 drops s_read while in ISSUE under m_waitrequest=1. Required: m_read=0 that cycle, the block returns to IDLE, and the next pending master after 1 is granted.

Source files
------------

// File: rtl/gpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gpu_pkg
//  Description : Types shared by the GPU memory arbiter and its sub-blocks.
//                arb_state_t is the 2-bit arbiter FSM state.
//  Revision    : 1.0 - initial release
// ============================================================================
package gpu_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE      = 2'd0,
        ARB_ISSUE     = 2'd1,
        ARB_WAIT_DATA = 2'd2
    } arb_state_t;

endpackage : gpu_pkg
`default_nettype wire

// File: rtl/gpu_rr_picker.sv
`default_nettype none
// ============================================================================
//  Module      : gpu_rr_picker
//  Description : Combinational round-robin selector. Picks the first set
//                request bit at or after last_grant+1, wrapping modulo
//                NUM_MASTERS.
//  Ports       : req        - per-master request vector
//                last_grant - index of the most recently served master
//                pick_idx   - selected master index (0 when none)
//                pick_valid - high when any request is set
//  Revision    : 1.0 - initial release
// ============================================================================
module gpu_rr_picker #(
    parameter int NUM_MASTERS = 4,
    parameter int IDX_BITS    = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IDX_BITS-1:0]    last_grant,
    output logic [IDX_BITS-1:0]    pick_idx,
    output logic                   pick_valid
);

    localparam logic [IDX_BITS:0] c_num_masters = (IDX_BITS+1)'(NUM_MASTERS);

    logic [IDX_BITS:0] w_cand;

    // Scan from the farthest offset down to the nearest so that the closest
    // requester after last_grant is the one left standing.
    always_comb begin
        pick_idx   = '0;
        pick_valid = 1'b0;
        w_cand     = '0;
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            w_cand = {1'b0, last_grant} + (IDX_BITS+1)'(k);
            if (w_cand >= c_num_masters) begin
                w_cand = w_cand - c_num_masters;
            end
            if (req[w_cand[IDX_BITS-1:0]]) begin
                pick_idx   = w_cand[IDX_BITS-1:0];
                pick_valid = 1'b1;
            end
        end
    end

endmodule : gpu_rr_picker
`default_nettype wire

// File: rtl/gpu_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : gpu_mem_arbiter
//  Description : Round-robin arbiter sharing one byte-wide Avalon-MM master
//                port among NUM_MASTERS tile controllers. One transaction is
//                in flight at a time; a read holds the port until its
//                readdatavalid returns.
//  Ports       : clock, reset          - clock, synchronous active-high reset
//                s_*                   - per-master Avalon slave side (packed)
//                m_*                   - downstream Avalon master side
//                grant_idx             - current / most recent grantee
//                busy                  - high whenever not IDLE
//  Revision    : 1.0 - initial release
// ============================================================================
module gpu_mem_arbiter
    import gpu_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_BITS   = 32,
    parameter int DATA_BITS   = 8,
    parameter int IDX_BITS    = $clog2(NUM_MASTERS)
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [NUM_MASTERS*ADDR_BITS-1:0] s_address,
    input  logic [NUM_MASTERS*DATA_BITS-1:0] s_writedata,
    input  logic [NUM_MASTERS-1:0]           s_read,
    input  logic [NUM_MASTERS-1:0]           s_write,
    output logic [NUM_MASTERS-1:0]           s_waitrequest,
    output logic [DATA_BITS-1:0]             s_readdata,
    output logic [NUM_MASTERS-1:0]           s_readdatavalid,
    output logic [ADDR_BITS-1:0]             m_address,
    output logic [DATA_BITS-1:0]             m_writedata,
    output logic                             m_read,
    output logic                             m_write,
    input  logic                             m_waitrequest,
    input  logic [DATA_BITS-1:0]             m_readdata,
    input  logic                             m_readdatavalid,
    output logic [IDX_BITS-1:0]              grant_idx,
    output logic                             busy
);

    arb_state_t            r_state;
    logic [IDX_BITS-1:0]   r_grant_idx;
    logic [IDX_BITS-1:0]   r_last_grant;
    logic                  r_busy;

    logic [NUM_MASTERS-1:0] w_req;
    logic [IDX_BITS-1:0]    w_pick_idx;
    logic                   w_pick_valid;
    logic [ADDR_BITS-1:0]   w_addr  [NUM_MASTERS];
    logic [DATA_BITS-1:0]   w_wdata [NUM_MASTERS];
    logic                   w_g_rd;
    logic                   w_g_wr;
    logic                   w_g_active;
    logic                   w_read_acc;

    generate
        for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_unpack
            assign w_addr[i]  = s_address[i*ADDR_BITS +: ADDR_BITS];
            assign w_wdata[i] = s_writedata[i*DATA_BITS +: DATA_BITS];
        end
    endgenerate

    assign w_req = s_read | s_write;

    gpu_rr_picker #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_BITS    (IDX_BITS)
    ) u_picker (
        .req        (w_req),
        .last_grant (r_last_grant),
        .pick_idx   (w_pick_idx),
        .pick_valid (w_pick_valid)
    );

    assign w_g_rd     = s_read[r_grant_idx];
    assign w_g_wr     = s_write[r_grant_idx];
    assign w_g_active = w_g_rd | w_g_wr;
    // Write has priority over a simultaneous read; the read stays pending.
    assign w_read_acc = w_g_rd & ~w_g_wr & ~m_waitrequest;

    assign s_readdata = m_readdata;
    assign grant_idx  = r_grant_idx;
    assign busy       = r_busy;

    // Only the grantee ever sees its stall released or a read strobe.
    always_comb begin
        m_address       = '0;
        m_writedata     = '0;
        m_read          = 1'b0;
        m_write         = 1'b0;
        s_waitrequest   = '1;
        s_readdatavalid = '0;
        case (r_state)
            ARB_ISSUE: begin
                m_write = w_g_wr;
                m_read  = w_g_rd & ~w_g_wr;
                if (w_g_active) begin
                    m_address   = w_addr[r_grant_idx];
                    m_writedata = w_wdata[r_grant_idx];
                end
                s_waitrequest[r_grant_idx]   = m_waitrequest;
                s_readdatavalid[r_grant_idx] = w_read_acc & m_readdatavalid;
            end
            ARB_WAIT_DATA: begin
                s_readdatavalid[r_grant_idx] = m_readdatavalid;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ARB_IDLE;
            r_grant_idx  <= '0;
            r_last_grant <= IDX_BITS'(NUM_MASTERS - 1);
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_pick_valid) begin
                        r_grant_idx <= w_pick_idx;
                        r_state     <= ARB_ISSUE;
                        r_busy      <= 1'b1;
                    end
                end
                ARB_ISSUE: begin
                    if (!w_g_active) begin
                        // Grantee withdrew: release the port to the others.
                        r_last_grant <= r_grant_idx;
                        r_state      <= ARB_IDLE;
                        r_busy       <= 1'b0;
                    end else if (!m_waitrequest) begin
                        if (w_g_wr || m_readdatavalid) begin
                            r_last_grant <= r_grant_idx;
                            r_state      <= ARB_IDLE;
                            r_busy       <= 1'b0;
                        end else begin
                            r_state <= ARB_WAIT_DATA;
                        end
                    end
                end
                ARB_WAIT_DATA: begin
                    if (m_readdatavalid) begin
                        r_last_grant <= r_grant_idx;
                        r_state      <= ARB_IDLE;
                        r_busy       <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule : gpu_mem_arbiter
`default_nettype wire

// File: tb/tb_gpu_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gpu_mem_arbiter
//  Description : Self-checking bench for gpu_mem_arbiter: vector table,
//                hand-written reset-in-WAIT_DATA sequence, and a randomized
//                run against a transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gpu_mem_arbiter;

    localparam int N  = 4;
    localparam int AB = 32;
    localparam int DB = 8;
    localparam int IB = 2;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [N*AB-1:0]   s_address = '0;
    logic [N*DB-1:0]   s_writedata = '0;
    logic [N-1:0]      s_read = '0;
    logic [N-1:0]      s_write = '0;
    logic [N-1:0]      s_waitrequest;
    logic [DB-1:0]     s_readdata;
    logic [N-1:0]      s_readdatavalid;
    logic [AB-1:0]     m_address;
    logic [DB-1:0]     m_writedata;
    logic              m_read;
    logic              m_write;
    logic              m_waitrequest = 1'b0;
    logic [DB-1:0]     m_readdata = '0;
    logic              m_readdatavalid = 1'b0;
    logic [IB-1:0]     grant_idx;
    logic              busy;

    gpu_mem_arbiter #(
        .NUM_MASTERS (N),
        .ADDR_BITS   (AB),
        .DATA_BITS   (DB),
        .IDX_BITS    (IB)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .s_address       (s_address),
        .s_writedata     (s_writedata),
        .s_read          (s_read),
        .s_write         (s_write),
        .s_waitrequest   (s_waitrequest),
        .s_readdata      (s_readdata),
        .s_readdatavalid (s_readdatavalid),
        .m_address       (m_address),
        .m_writedata     (m_writedata),
        .m_read          (m_read),
        .m_write         (m_write),
        .m_waitrequest   (m_waitrequest),
        .m_readdata      (m_readdata),
        .m_readdatavalid (m_readdatavalid),
        .grant_idx       (grant_idx),
        .busy            (busy)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    logic [AB-1:0] addr [N];
    logic [DB-1:0] wd   [N];

    localparam logic [AB-1:0] A0 = 32'h0000_0100;
    localparam logic [AB-1:0] A1 = 32'h0000_2004;
    localparam logic [AB-1:0] A2 = 32'h0000_1000;
    localparam logic [AB-1:0] A3 = 32'h0000_3FF8;

    typedef struct {
        logic          rst;
        logic [N-1:0]  rd;
        logic [N-1:0]  wr;
        logic          mw;
        logic          rdv;
        logic [DB-1:0] md;
        logic          e_mrd;
        logic          e_mwr;
        logic [AB-1:0] e_addr;
        logic [DB-1:0] e_wd;
        logic [N-1:0]  e_sw;
        logic [N-1:0]  e_srdv;
        logic [IB-1:0] e_g;
        logic          e_busy;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic rst, input logic [N-1:0] rd, input logic [N-1:0] wr,
                                input logic mw, input logic rdv, input logic [DB-1:0] md,
                                input logic e_mrd, input logic e_mwr, input logic [AB-1:0] e_addr,
                                input logic [DB-1:0] e_wd, input logic [N-1:0] e_sw,
                                input logic [N-1:0] e_srdv, input logic [IB-1:0] e_g, input logic e_busy);
        vec_t v;
        v.rst = rst; v.rd = rd; v.wr = wr; v.mw = mw; v.rdv = rdv; v.md = md;
        v.e_mrd = e_mrd; v.e_mwr = e_mwr; v.e_addr = e_addr; v.e_wd = e_wd;
        v.e_sw = e_sw; v.e_srdv = e_srdv; v.e_g = e_g; v.e_busy = e_busy;
        return v;
    endfunction

    task automatic drive(input logic [N-1:0] rd, input logic [N-1:0] wr,
                         input logic mw, input logic rdv, input logic [DB-1:0] md);
        for (int i = 0; i < N; i++) begin
            s_address[i*AB +: AB]   = addr[i];
            s_writedata[i*DB +: DB] = wd[i];
        end
        s_read          = rd;
        s_write         = wr;
        m_waitrequest   = mw;
        m_readdatavalid = rdv;
        m_readdata      = md;
    endtask

    task automatic check(input string nm, input logic e_mrd, input logic e_mwr,
                         input logic [AB-1:0] e_addr, input logic [DB-1:0] e_wd,
                         input logic [N-1:0] e_sw, input logic [N-1:0] e_srdv,
                         input logic [DB-1:0] e_sd, input logic [IB-1:0] e_g, input logic e_busy);
        checks++;
        if ({m_read, m_write, m_address, m_writedata, s_waitrequest, s_readdatavalid,
             s_readdata, grant_idx, busy} !==
            {e_mrd, e_mwr, e_addr, e_wd, e_sw, e_srdv, e_sd, e_g, e_busy}) begin
            failures++;
            $display("FAIL %s: got rd=%b wr=%b addr=%h wd=%h sw=%b srdv=%b sd=%h g=%0d busy=%b ; want rd=%b wr=%b addr=%h wd=%h sw=%b srdv=%b sd=%h g=%0d busy=%b",
                     nm, m_read, m_write, m_address, m_writedata, s_waitrequest, s_readdatavalid,
                     s_readdata, grant_idx, busy,
                     e_mrd, e_mwr, e_addr, e_wd, e_sw, e_srdv, e_sd, e_g, e_busy);
        end
    endtask

    // Holds reset across one rising edge; returns at a falling edge with reset low.
    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        drive('0, '0, 1'b0, 1'b0, '0);
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Reference-model state for the randomized run.
    logic [N-1:0] q_rd, q_wr;
    int           phase;   // 0 idle, 1 issue, 2 waiting for data
    int           owner;
    int           last;
    int           exp_g;
    int           lat;
    int           ntx;
    int           kind;
    logic         mw, rdv, found;
    logic [DB-1:0] md;
    logic          e_mrd, e_mwr, e_busy;
    logic [AB-1:0] e_addr;
    logic [DB-1:0] e_wd;
    logic [N-1:0]  e_sw, e_srdv;

    initial begin
        addr[0] = A0; addr[1] = A1; addr[2] = A2; addr[3] = A3;
        wd[0] = 8'h11; wd[1] = 8'h22; wd[2] = 8'h33; wd[3] = 8'h44;

        // Master 2 read with two wait cycles then data three cycles later.
        vt.push_back(mk(1, 4'b0100, 4'b0000, 0, 0, 8'h00, 0, 0, '0,   8'h00, 4'b1111, 4'b0000, 0, 0));
        vt.push_back(mk(0, 4'b0100, 4'b0000, 1, 0, 8'h00, 1, 0, A2,   8'h33, 4'b1111, 4'b0000, 2, 1));
        vt.push_back(mk(0, 4'b0100, 4'b0000, 1, 0, 8'h00, 1, 0, A2,   8'h33, 4'b1111, 4'b0000, 2, 1));
        vt.push_back(mk(0, 4'b0100, 4'b0000, 0, 0, 8'h00, 1, 0, A2,   8'h33, 4'b1011, 4'b0000, 2, 1));
        vt.push_back(mk(0, 4'b0000, 4'b0000, 0, 0, 8'h00, 0, 0, '0,   8'h00, 4'b1111, 4'b0000, 2, 1));
        vt.push_back(mk(0, 4'b0000, 4'b0000, 0, 0, 8'h00, 0, 0, '0,   8'h00, 4'b1111, 4'b0000, 2, 1));
        vt.push_back(mk(0, 4'b0000, 4'b0000, 0, 1, 8'hA5, 0, 0, '0,   8'h00, 4'b1111, 4'b0100, 2, 1));
        vt.push_back(mk(0, 4'b0000, 4'b0000, 0, 0, 8'h00, 0, 0, '0,   8'h00, 4'b1111, 4'b0000, 2, 0));
        // All four masters write continuously: grants 0,1,2,3,0.
        vt.push_back(mk(1, 4'b0000, 4'b1111, 0, 0, 8'h00, 0, 0, '0,   8'h00, 4'b1111, 4'b0000, 0, 0));
        vt.push_back(mk(0, 4'b0000, 4'b1111, 0, 0, 8'h00, 0, 1, A0,   8'h11, 4'b1110, 4'b0000, 0, 1));
        vt.push_back(mk(0, 4'b0000, 4'b1111, 0, 0, 8'h00, 0, 0, '0,   8'h00, 4'b1111, 4'b0000, 0, 0));
        vt.push_back(mk(0, 4'b0000, 4'b1111, 0, 0, 8'h00, 0, 1, A1,   8'h22, 4'b1101, 4'b0000, 1, 1));
        vt.push_back(mk(0, 4'b0000, 4'b1111, 0, 0, 8'h00, 0, 0, '0,   8'h00, 4'b1111, 4'b0000, 1, 0));
        vt.push_back(mk(0, 4'b0000, 4'b1111, 0, 0, 8'h00, 0, 1, A2,   8'h33, 4'b1011, 4'b0000, 2, 1));
        vt.push_back(mk(0, 4'b0000, 4'b1111, 0, 0, 8'h00, 0, 0, '0,   8'h00, 4'b1111, 4'b0000, 2, 0));
        vt.push_back(mk(0, 4'b0000, 4'b1111, 0, 0, 8'h00, 0, 1, A3,   8'h44, 4'b0111, 4'b0000, 3, 1));
        vt.push_back(mk(0, 4'b0000, 4'b1111, 0, 0, 8'h00, 0, 0, '0,   8'h00, 4'b1111, 4'b0000, 3, 0));
        vt.push_back(mk(0, 4'b0000, 4'b1111, 0, 0, 8'h00, 0, 1, A0,   8'h11, 4'b1110, 4'b0000, 0, 1));
        // last_grant=1 with masters 1 and 3 requesting: 3 first, then 1.
        vt.push_back(mk(1, 4'b0000, 4'b0010, 0, 0, 8'h00, 0, 0, '0,   8'h00, 4'b1111, 4'b0000, 0, 0));
        vt.push_back(mk(0, 4'b0000, 4'b0010, 0, 0, 8'h00, 0, 1, A1,   8'h22, 4'b1101, 4'b0000, 1, 1));
        vt.push_back(mk(0, 4'b0000, 4'b1010, 0, 0, 8'h00, 0, 0, '0,   8'h00, 4'b1111, 4'b0000, 1, 0));
        vt.push_back(mk(0, 4'b0000, 4'b1010, 0, 0, 8'h00, 0, 1, A3,   8'h44, 4'b0111, 4'b0000, 3, 1));
        vt.push_back(mk(0, 4'b0000, 4'b0010, 0, 0, 8'h00, 0, 0, '0,   8'h00, 4'b1111, 4'b0000, 3, 0));
        vt.push_back(mk(0, 4'b0000, 4'b0010, 0, 0, 8'h00, 0, 1, A1,   8'h22, 4'b1101, 4'b0000, 1, 1));
        // Zero-latency read by master 0; a later strobe in IDLE is dropped.
        vt.push_back(mk(1, 4'b0001, 4'b0000, 0, 0, 8'h00, 0, 0, '0,   8'h00, 4'b1111, 4'b0000, 0, 0));
        vt.push_back(mk(0, 4'b0001, 4'b0000, 0, 1, 8'h3C, 1, 0, A0,   8'h11, 4'b1110, 4'b0001, 0, 1));
        vt.push_back(mk(0, 4'b0000, 4'b0000, 0, 1, 8'h5A, 0, 0, '0,   8'h00, 4'b1111, 4'b0000, 0, 0));
        // Grantee 1 withdraws its read while stalled; master 3 is next.
        vt.push_back(mk(1, 4'b1010, 4'b0000, 1, 0, 8'h00, 0, 0, '0,   8'h00, 4'b1111, 4'b0000, 0, 0));
        vt.push_back(mk(0, 4'b1010, 4'b0000, 1, 0, 8'h00, 1, 0, A1,   8'h22, 4'b1111, 4'b0000, 1, 1));
        vt.push_back(mk(0, 4'b1000, 4'b0000, 1, 0, 8'h00, 0, 0, '0,   8'h00, 4'b1111, 4'b0000, 1, 1));
        vt.push_back(mk(0, 4'b1000, 4'b0000, 1, 0, 8'h00, 0, 0, '0,   8'h00, 4'b1111, 4'b0000, 1, 0));
        vt.push_back(mk(0, 4'b1000, 4'b0000, 1, 0, 8'h00, 1, 0, A3,   8'h44, 4'b1111, 4'b0000, 3, 1));

        for (int k = 0; k < vt.size(); k++) begin
            if (vt[k].rst) do_reset();
            else @(negedge clock);
            drive(vt[k].rd, vt[k].wr, vt[k].mw, vt[k].rdv, vt[k].md);
            #2;
            check($sformatf("vec%0d", k), vt[k].e_mrd, vt[k].e_mwr, vt[k].e_addr, vt[k].e_wd,
                  vt[k].e_sw, vt[k].e_srdv, vt[k].md, vt[k].e_g, vt[k].e_busy);
        end

        // Reset while waiting for read data; the late strobe must be dropped.
        do_reset();
        drive(4'b0100, 4'b0000, 1'b0, 1'b0, 8'h00);
        @(negedge clock);
        drive(4'b0100, 4'b0000, 1'b0, 1'b0, 8'h00);
        @(negedge clock);
        reset = 1'b1;
        drive(4'b0000, 4'b0000, 1'b0, 1'b0, 8'h00);
        #2;
        check("wait_data_entered", 0, 0, '0, 8'h00, 4'b1111, 4'b0000, 8'h00, 2, 1);
        @(negedge clock);
        reset = 1'b0;
        drive(4'b0101, 4'b0000, 1'b0, 1'b1, 8'h77);
        #2;
        check("after_reset_late_strobe", 0, 0, '0, 8'h00, 4'b1111, 4'b0000, 8'h77, 0, 0);
        @(negedge clock);
        drive(4'b0101, 4'b0000, 1'b1, 1'b0, 8'h00);
        #2;
        check("first_grant_after_reset", 1, 0, A0, 8'h11, 4'b1111, 4'b0000, 8'h00, 0, 1);

        // Randomized traffic against the reference model.
        do_reset();
        q_rd = '0; q_wr = '0;
        phase = 0; owner = 0; last = N - 1; exp_g = 0; lat = 0; ntx = 0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            if (cyc != 0) @(negedge clock);
            for (int i = 0; i < N; i++) begin
                if (!(q_rd[i] | q_wr[i])) begin
                    if ($urandom_range(0, 3) == 0) begin
                        kind    = int'($urandom_range(0, 4));
                        q_rd[i] = (kind <= 1) || (kind == 4);
                        q_wr[i] = (kind >= 2);
                        addr[i] = $urandom;
                        wd[i]   = 8'($urandom);
                    end
                end else if ($urandom_range(0, 31) == 0) begin
                    q_rd[i] = 1'b0;
                    q_wr[i] = 1'b0;
                end
            end
            mw = ($urandom_range(0, 2) == 0);
            md = 8'($urandom);
            if (phase == 2) rdv = (lat == 0);
            else if (phase == 1 && q_rd[owner] && !q_wr[owner] && !mw) rdv = ($urandom_range(0, 3) == 0);
            else rdv = ($urandom_range(0, 7) == 0);
            drive(q_rd, q_wr, mw, rdv, md);
            #2;

            e_mrd = 0; e_mwr = 0; e_addr = '0; e_wd = '0; e_sw = '1; e_srdv = '0;
            e_busy = (phase != 0);
            if (phase == 1) begin
                e_mwr = q_wr[owner];
                e_mrd = q_rd[owner] && !q_wr[owner];
                if (q_rd[owner] || q_wr[owner]) begin
                    e_addr = addr[owner];
                    e_wd   = wd[owner];
                end
                e_sw[owner]   = mw;
                e_srdv[owner] = e_mrd && !mw && rdv;
            end else if (phase == 2) begin
                e_srdv[owner] = rdv;
            end
            check($sformatf("rand%0d", cyc), e_mrd, e_mwr, e_addr, e_wd, e_sw, e_srdv, md,
                  IB'(exp_g), e_busy);

            if (phase == 0) begin
                found = 1'b0;
                for (int off = 1; off <= N; off++) begin
                    if (!found && (q_rd[(last + off) % N] || q_wr[(last + off) % N])) begin
                        owner = (last + off) % N;
                        found = 1'b1;
                    end
                end
                if (found) begin
                    phase = 1;
                    exp_g = owner;
                end
            end else if (phase == 1) begin
                if (!(q_rd[owner] || q_wr[owner])) begin
                    last  = owner;
                    phase = 0;
                end else if (!mw) begin
                    ntx++;
                    if (q_wr[owner]) begin
                        q_wr[owner] = 1'b0;
                        last  = owner;
                        phase = 0;
                    end else begin
                        q_rd[owner] = 1'b0;
                        if (rdv) begin
                            last  = owner;
                            phase = 0;
                        end else begin
                            phase = 2;
                            lat   = int'($urandom_range(0, 3));
                        end
                    end
                end
            end else begin
                if (rdv) begin
                    last  = owner;
                    phase = 0;
                end else begin
                    lat--;
                end
            end
        end

        checks++;
        if (ntx < 50) begin
            failures++;
            $display("FAIL rand_progress: got %0d transactions, want at least 50", ntx);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_gpu_mem_arbiter
`default_nettype wire
